rv32imf_obi_arbiter: RTL and testbench
======================================

# rv32imf_obi_arbiter

Two-to-one arbiter sharing a single OBI transaction port between the data (LSU) requester and the instruction-fetch requester. It sits upstream of the core's OBI interface block and drives its transaction request interface. Each downstream response is routed back to the requester that issued the matching request, using an in-order ID FIFO, since OBI returns responses in order. The number of outstanding transactions is bounded.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered transactions (1..8); sets the ID FIFO depth.
- clk  in  1  clock. One clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- d_valid_i / d_ready_o  in/out  1/1  data requester handshake (port 0).
- d_addr_i, d_we_i, d_be_i, d_wdata_i, d_atop_i  in  32/1/4/32/6  data request payload.
- i_valid_i / i_ready_o  in/out  1/1  fetch requester handshake (port 1).
- i_addr_i  in  32  fetch address. Fetch is read-only: we=0, be=4'hF, wdata=0, atop=0 are forced downstream.
- trans_valid_o / trans_ready_i  out/in  1/1  downstream request handshake.
- trans_addr_o, trans_we_o, trans_be_o, trans_wdata_o, trans_atop_o  out  32/1/4/32/6  selected payload.
- resp_valid_i, resp_rdata_i, resp_err_i  in  1/32/1  downstream response. No backpressure.
- d_resp_valid_o, d_resp_rdata_o, d_resp_err_o  out  1/32/1  data response.
- i_resp_valid_o, i_resp_rdata_o, i_resp_err_o  out  1/32/1  fetch response.

## Operation
- Arbitration is combinational: trans_valid_o = (d_valid_i | i_valid_i) & !full. The payload is muxed from the selected port.
- Default policy is fixed priority, data over fetch.
- Grant lock:
  - If trans_valid_o=1 and trans_ready_i=0, a lock register stores the selected port.
  - While locked, that port stays selected regardless of the other port's valid.
  - The lock clears on acceptance.
  - If the locked requester drops valid, the lock clears and arbitration restarts the same cycle.
- Port ready: x_ready_o = selected(x) & trans_ready_i & !full. The non-selected port always sees ready=0.
- Accept (trans_valid_o & trans_ready_i): push the selected port ID (0=data, 1=fetch) into the ID FIFO.
- Response: on resp_valid_i, pop the FIFO head and route rdata/err to that port's resp_* outputs. The other port's resp_valid is 0. rdata/err are broadcast to both ports; only the valid is steered.
- Count rules:
  - full = (count == MAX_OUTSTANDING). The full check does not credit a same-cycle pop, so there is no resp→req combinational path.
  - A simultaneous push and pop leaves count unchanged. The pointers wrap modulo MAX_OUTSTANDING.
  - resp_valid_i with count==0 is a protocol error: the response is dropped, no resp_valid output is raised, and an SVA assertion fires.
- Reset:
  - All *_resp_valid_o, trans_valid_o, d_ready_o and i_ready_o are 0 during reset. All payload outputs are 0.
  - Count, pointers, lock and the round-robin pointer are cleared.
  - Reset asserted mid-transaction discards all outstanding IDs. Responses that arrive after reset are treated as the protocol error above.

## Timing
- Request path: 0-cycle combinational from x_valid_i to trans_valid_o.
- Response path: 0-cycle combinational from resp_valid_i to x_resp_valid_o.
- Lock, count and round-robin pointer update at the rising clk edge following the event.
- Back-to-back accepts: one per cycle until full.
- A pop in cycle N re-enables request issue in cycle N+1.

## Configuration
- RV32IMF_OBI_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-granted register updates on each accept.
  - When both ports are valid and unlocked, the port not last granted wins.
  - Reset value of the register is "fetch last", so data wins first.
- RV32IMF_OBI_ARB_RR_EN undefined: fixed priority, data over fetch. The register is not instantiated.

## Structure
- Package rv32imf_obi_arb_pkg holds:
  - typedef obi_port_e with values PORT_DATA=1'b0 and PORT_INSTR=1'b1.
  - Constants for the forced fetch payload (BE_ALL=4'hF, ATOP_NONE=6'h0).
- Sub-module rv32imf_obi_arb_id_fifo: parameterised depth, 1-bit-wide, synchronous FIFO.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Handles the simultaneous push/pop case.
- The arbiter top holds the mux, lock and round-robin logic.

## Test plan
- Only d_valid_i=1, addr=0x100, we=1, be=4'h3, trans_ready_i=1 → trans_addr_o=0x100 and d_ready_o=1 the same cycle. A later resp_valid_i with rdata=0xDEADBEEF → d_resp_valid_o=1, i_resp_valid_o=0.
- Both valid, trans_ready_i=0 for 3 cycles and then 1 (fixed priority) → data stays selected all 4 cycles, i_ready_o=0 throughout, and fetch is accepted the cycle after.
- MAX_OUTSTANDING=2, two fetch accepts and no responses → third fetch sees trans_valid_o=0. A response in cycle N → fetch is issued in N+1 and the first response goes to i_resp.
- Interleaved accepts D, I, D followed by 3 responses with rdata 1, 2, 3 → d gets 1, i gets 2, d gets 3. Err=1 on the second response appears only on i_resp_err_o with i_resp_valid_o.
- With RV32IMF_OBI_ARB_RR_EN, both ports continuously valid and trans_ready_i=1 → grants alternate D, I, D, I from reset.
- rst_n asserted with 2 outstanding, then released, then resp_valid_i=1 → no resp_valid output and the assertion fires. A new request issues normally.

Source files
------------

// File: rtl/rv32imf_obi_arb_pkg.sv
// Shared types and constants for the two-to-one OBI request arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
//
// Contents: obi_port_e requester IDs, forced fetch payload constants and the
// obi_req_t request payload bundle.
package rv32imf_obi_arb_pkg;

    typedef enum logic {
        PORT_DATA  = 1'b0,
        PORT_INSTR = 1'b1
    } obi_port_e;

    // Fetch is read-only: these fields are forced on the fetch path.
    localparam logic [3:0]  BE_ALL     = 4'hF;
    localparam logic [5:0]  ATOP_NONE  = 6'h0;
    localparam logic [31:0] WDATA_NONE = 32'h0;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [5:0]  atop;
    } obi_req_t;

endpackage

// File: rtl/rv32imf_obi_arb_id_fifo.sv
// Synchronous 1-bit FIFO holding the requester ID of each outstanding transaction.
// Latency: rdata shows the head combinationally; a push becomes visible at the next clk edge.
// Backpressure: push is ignored while full and pop is ignored while empty; push+pop together keeps count.
//
// Ports: clk, rst_n (async active-low); push/wdata write side; pop/rdata read side;
// full/empty status decoded from the registered count.
module rv32imf_obi_arb_id_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic wdata,
    output logic rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign rdata  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rv32imf_obi_arbiter.sv
// Two-to-one arbiter sharing one OBI transaction port between LSU (port 0) and fetch (port 1).
// Latency: 0 cycles request path (valid->trans_valid) and response path (resp_valid->x_resp_valid).
// Backpressure: trans_ready_i stalls the selected port (grant locked until accept); issue stops at MAX_OUTSTANDING.
//
// Ports: clk, rst_n (async active-low); d_* data requester (full payload); i_* fetch requester
// (address only, read-only payload forced); trans_* downstream request; resp_* downstream response
// (no backpressure); d_resp_* / i_resp_* routed responses.
// Build option: define RV32IMF_OBI_ARB_RR_EN for round-robin arbitration (default: data over fetch).
module rv32imf_obi_arbiter
    import rv32imf_obi_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        d_valid_i,
    output logic        d_ready_o,
    input  logic [31:0] d_addr_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_be_i,
    input  logic [31:0] d_wdata_i,
    input  logic [5:0]  d_atop_i,
    input  logic        i_valid_i,
    output logic        i_ready_o,
    input  logic [31:0] i_addr_i,
    output logic        trans_valid_o,
    input  logic        trans_ready_i,
    output logic [31:0] trans_addr_o,
    output logic        trans_we_o,
    output logic [3:0]  trans_be_o,
    output logic [31:0] trans_wdata_o,
    output logic [5:0]  trans_atop_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_rdata_i,
    input  logic        resp_err_i,
    output logic        d_resp_valid_o,
    output logic [31:0] d_resp_rdata_o,
    output logic        d_resp_err_o,
    output logic        i_resp_valid_o,
    output logic [31:0] i_resp_rdata_o,
    output logic        i_resp_err_o
);

    obi_port_e r_lock_port;
    logic      r_lock_vld;
`ifdef RV32IMF_OBI_ARB_RR_EN
    obi_port_e r_last;
`endif

    obi_port_e w_sel;
    obi_req_t  w_d_req;
    obi_req_t  w_i_req;
    obi_req_t  w_sel_req;
    logic      w_any;
    logic      w_full;
    logic      w_empty;
    logic      w_acc;
    logic      w_stall;
    logic      w_pop;
    logic      w_head;
    logic      w_lock_live;

    assign w_d_req = '{addr: d_addr_i, we: d_we_i, be: d_be_i, wdata: d_wdata_i, atop: d_atop_i};
    assign w_i_req = '{addr: i_addr_i, we: 1'b0, be: BE_ALL, wdata: WDATA_NONE, atop: ATOP_NONE};

    // A lock only holds while its owner still requests; otherwise arbitrate afresh this cycle.
    assign w_lock_live = r_lock_vld & ((r_lock_port == PORT_DATA) ? d_valid_i : i_valid_i);

    always_comb begin
        w_sel = PORT_DATA;
        if (w_lock_live) begin
            w_sel = r_lock_port;
        end else if (d_valid_i && i_valid_i) begin
`ifdef RV32IMF_OBI_ARB_RR_EN
            w_sel = (r_last == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
`else
            w_sel = PORT_DATA;
`endif
        end else if (i_valid_i) begin
            w_sel = PORT_INSTR;
        end
    end

    // Full uses the registered count only, so resp_valid_i never reaches the request side.
    assign w_any         = d_valid_i | i_valid_i;
    assign trans_valid_o = rst_n & w_any & ~w_full;
    assign w_acc         = trans_valid_o & trans_ready_i;
    assign w_stall       = trans_valid_o & ~trans_ready_i;
    assign d_ready_o     = trans_valid_o & trans_ready_i & (w_sel == PORT_DATA);
    assign i_ready_o     = trans_valid_o & trans_ready_i & (w_sel == PORT_INSTR);

    always_comb begin
        w_sel_req = '0;
        if (rst_n) begin
            w_sel_req = (w_sel == PORT_DATA) ? w_d_req : w_i_req;
        end
    end

    assign trans_addr_o  = w_sel_req.addr;
    assign trans_we_o    = w_sel_req.we;
    assign trans_be_o    = w_sel_req.be;
    assign trans_wdata_o = w_sel_req.wdata;
    assign trans_atop_o  = w_sel_req.atop;

    rv32imf_obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_acc),
        .pop   (w_pop),
        .wdata (w_sel),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // A response with nothing outstanding is dropped; only the valid is steered.
    assign w_pop          = resp_valid_i & ~w_empty;
    assign d_resp_valid_o = w_pop & (w_head == PORT_DATA);
    assign i_resp_valid_o = w_pop & (w_head == PORT_INSTR);
    assign d_resp_rdata_o = rst_n ? resp_rdata_i : 32'h0;
    assign i_resp_rdata_o = rst_n ? resp_rdata_i : 32'h0;
    assign d_resp_err_o   = rst_n & resp_err_i;
    assign i_resp_err_o   = rst_n & resp_err_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_vld  <= 1'b0;
            r_lock_port <= PORT_DATA;
        end else begin
            r_lock_vld <= w_stall;
            if (w_stall) begin
                r_lock_port <= w_sel;
            end
        end
    end

`ifdef RV32IMF_OBI_ARB_RR_EN
    // Resets to "fetch last" so data wins the first contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_INSTR;
        end else if (w_acc) begin
            r_last <= w_sel;
        end
    end
`endif

`ifndef SYNTHESIS
    a_resp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid_i |-> !w_empty)
        else $warning("rv32imf_obi_arbiter: response with no outstanding request dropped");
`endif

endmodule

// File: tb/tb_rv32imf_obi_arbiter.sv
// Scoreboard bench for rv32imf_obi_arbiter: directed stimulus pushes expected grants/responses,
// a negedge monitor pops and compares them whenever the DUT accepts or responds.
// Covers reset, single data access, stall/lock, full blocking, ID routing, reset discard, streaming.
module tb_rv32imf_obi_arbiter;
    import rv32imf_obi_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_valid_i, d_ready_o, d_we_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic [3:0]  d_be_i;
    logic [5:0]  d_atop_i;
    logic        i_valid_i, i_ready_o;
    logic [31:0] i_addr_i;
    logic        trans_valid_o, trans_ready_i, trans_we_o;
    logic [31:0] trans_addr_o, trans_wdata_o;
    logic [3:0]  trans_be_o;
    logic [5:0]  trans_atop_o;
    logic        resp_valid_i, resp_err_i;
    logic [31:0] resp_rdata_i;
    logic        d_resp_valid_o, d_resp_err_o, i_resp_valid_o, i_resp_err_o;
    logic [31:0] d_resp_rdata_o, i_resp_rdata_o;

    always #5 clk = ~clk;

    rv32imf_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_addr_i(d_addr_i), .d_we_i(d_we_i),
        .d_be_i(d_be_i), .d_wdata_i(d_wdata_i), .d_atop_i(d_atop_i),
        .i_valid_i(i_valid_i), .i_ready_o(i_ready_o), .i_addr_i(i_addr_i),
        .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i), .trans_addr_o(trans_addr_o),
        .trans_we_o(trans_we_o), .trans_be_o(trans_be_o), .trans_wdata_o(trans_wdata_o),
        .trans_atop_o(trans_atop_o),
        .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i), .resp_err_i(resp_err_i),
        .d_resp_valid_o(d_resp_valid_o), .d_resp_rdata_o(d_resp_rdata_o), .d_resp_err_o(d_resp_err_o),
        .i_resp_valid_o(i_resp_valid_o), .i_resp_rdata_o(i_resp_rdata_o), .i_resp_err_o(i_resp_err_o)
    );

    typedef struct packed {
        logic [1:0]  rdy;     // {d_ready_o, i_ready_o} at the accept
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [5:0]  atop;
    } trans_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    trans_t tq[$];
    resp_t  dq[$];
    resp_t  iq[$];
    int     n_vec  = 0;
    int     n_miss = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_data(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, input logic [5:0] at);
        tq.push_back('{rdy: 2'b10, addr: a, we: we, be: be, wdata: wd, atop: at});
    endtask

    task automatic exp_fetch(input logic [31:0] a);
        tq.push_back('{rdy: 2'b01, addr: a, we: 1'b0, be: 4'hF, wdata: 32'h0, atop: 6'h0});
    endtask

    task automatic exp_resp(input bit to_instr, input logic [31:0] rd, input logic err);
        if (to_instr) iq.push_back('{rdata: rd, err: err});
        else          dq.push_back('{rdata: rd, err: err});
    endtask

    task automatic set_d(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic [5:0] at);
        d_valid_i = 1'b1; d_addr_i = a; d_we_i = we; d_be_i = be; d_wdata_i = wd; d_atop_i = at;
    endtask

    task automatic set_resp(input logic [31:0] rd, input logic err);
        resp_valid_i = 1'b1; resp_rdata_i = rd; resp_err_i = err;
    endtask

    task automatic idle();
        d_valid_i = 1'b0; i_valid_i = 1'b0; resp_valid_i = 1'b0;
        resp_rdata_i = 32'h0; resp_err_i = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every accept and every response against the scoreboard queues.
    always @(negedge clk) begin
        trans_t act_t;
        resp_t  act_r;
        if (trans_valid_o && trans_ready_i) begin
            act_t = '{rdy: {d_ready_o, i_ready_o}, addr: trans_addr_o, we: trans_we_o,
                      be: trans_be_o, wdata: trans_wdata_o, atop: trans_atop_o};
            chk("accept_queued", 128'(tq.size() > 0), 128'd1);
            if (tq.size() > 0) chk("accept_payload", 128'(act_t), 128'(tq.pop_front()));
        end
        if (d_resp_valid_o) begin
            act_r = '{rdata: d_resp_rdata_o, err: d_resp_err_o};
            chk("d_resp_queued", 128'(dq.size() > 0), 128'd1);
            if (dq.size() > 0) chk("d_resp", 128'(act_r), 128'(dq.pop_front()));
        end
        if (i_resp_valid_o) begin
            act_r = '{rdata: i_resp_rdata_o, err: i_resp_err_o};
            chk("i_resp_queued", 128'(iq.size() > 0), 128'd1);
            if (iq.size() > 0) chk("i_resp", 128'(act_r), 128'(iq.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit p1;
        bit g[4];
`ifdef RV32IMF_OBI_ARB_RR_EN
        p1 = 1'b1;                     // data granted last in test 1, so fetch wins
        g  = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        p1 = 1'b0;
        g  = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        // ---- Reset: outputs quiet despite active inputs
        rst_n = 1'b0; trans_ready_i = 1'b1; i_addr_i = 32'h0;
        idle();
        set_d(32'h55, 1'b1, 4'h3, 32'h77, 6'h1);
        i_valid_i = 1'b1; i_addr_i = 32'h66;
        set_resp(32'h99, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_trans_valid", trans_valid_o, 0);
        chk("rst_readys", {d_ready_o, i_ready_o}, 0);
        chk("rst_payload", {trans_addr_o, trans_we_o, trans_be_o, trans_wdata_o, trans_atop_o}, 0);
        chk("rst_resp_valids", {d_resp_valid_o, i_resp_valid_o}, 0);
        chk("rst_resp_data", {d_resp_rdata_o, d_resp_err_o, i_resp_rdata_o, i_resp_err_o}, 0);
        nxt(); idle(); rst_n = 1'b1;
        nxt();

        // ---- Test 1: single data write and its response
        set_d(32'h100, 1'b1, 4'h3, 32'hA5A5_0001, 6'h0);
        exp_data(32'h100, 1'b1, 4'h3, 32'hA5A5_0001, 6'h0);
        @(negedge clk);
        chk("t1_d_ready", d_ready_o, 1);
        chk("t1_addr", trans_addr_o, 32'h100);
        nxt(); idle(); set_resp(32'hDEAD_BEEF, 1'b0); exp_resp(1'b0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("t1_d_resp_valid", d_resp_valid_o, 1);
        chk("t1_i_resp_valid", i_resp_valid_o, 0);
        nxt(); idle();

        // ---- Test 2: both valid, 3 stall cycles then accept
        trans_ready_i = 1'b0;
        set_d(32'h200, 1'b0, 4'hC, 32'h1234_5678, 6'h21);
        i_valid_i = 1'b1; i_addr_i = 32'h300;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_stall_valid", trans_valid_o, 1);
            chk("t2_stall_addr", trans_addr_o, p1 ? 32'h300 : 32'h200);
            chk("t2_stall_readys", {d_ready_o, i_ready_o}, 0);
            nxt();
        end
        trans_ready_i = 1'b1;
        if (p1) begin exp_fetch(32'h300); exp_data(32'h200, 1'b0, 4'hC, 32'h1234_5678, 6'h21); end
        else    begin exp_data(32'h200, 1'b0, 4'hC, 32'h1234_5678, 6'h21); exp_fetch(32'h300); end
        @(negedge clk);
        chk("t2_first_ready", {d_ready_o, i_ready_o}, p1 ? 2'b01 : 2'b10);
        nxt();
        if (p1) i_valid_i = 1'b0; else d_valid_i = 1'b0;
        @(negedge clk);
        chk("t2_second_ready", {d_ready_o, i_ready_o}, p1 ? 2'b10 : 2'b01);
        nxt(); idle();
        set_resp(32'h11, 1'b0); exp_resp(p1, 32'h11, 1'b0);
        nxt(); set_resp(32'h22, 1'b0); exp_resp(~p1, 32'h22, 1'b0);
        nxt(); idle();

        // ---- Lock: stalled fetch keeps the grant when data arrives
        trans_ready_i = 1'b0; i_valid_i = 1'b1; i_addr_i = 32'h340;
        nxt();
        set_d(32'h240, 1'b1, 4'hF, 32'h0BAD_F00D, 6'h0);
        @(negedge clk);
        chk("lock_hold_addr", trans_addr_o, 32'h340);
        nxt();
        trans_ready_i = 1'b1;
        exp_fetch(32'h340); exp_data(32'h240, 1'b1, 4'hF, 32'h0BAD_F00D, 6'h0);
        nxt(); i_valid_i = 1'b0;
        nxt(); idle();
        set_resp(32'h31, 1'b0); exp_resp(1'b1, 32'h31, 1'b0);
        nxt(); set_resp(32'h32, 1'b0); exp_resp(1'b0, 32'h32, 1'b0);
        nxt(); idle();

        // ---- Lock release: locked fetch drops valid, data selected the same cycle
        trans_ready_i = 1'b0; i_valid_i = 1'b1; i_addr_i = 32'h350;
        nxt();
        i_valid_i = 1'b0; set_d(32'h250, 1'b0, 4'h1, 32'h0, 6'h3);
        @(negedge clk);
        chk("lock_drop_addr", trans_addr_o, 32'h250);
        nxt();
        trans_ready_i = 1'b1; exp_data(32'h250, 1'b0, 4'h1, 32'h0, 6'h3);
        nxt(); idle();
        set_resp(32'h41, 1'b0); exp_resp(1'b0, 32'h41, 1'b0);
        nxt(); idle();

        // ---- Test 3: full after two fetches, pop re-enables issue next cycle
        i_valid_i = 1'b1; i_addr_i = 32'h400; exp_fetch(32'h400);
        nxt(); i_addr_i = 32'h404; exp_fetch(32'h404);
        nxt(); i_addr_i = 32'h408; exp_fetch(32'h408);
        @(negedge clk);
        chk("t3_full_valid", trans_valid_o, 0);
        chk("t3_full_ready", i_ready_o, 0);
        nxt(); set_resp(32'h33, 1'b0); exp_resp(1'b1, 32'h33, 1'b0);
        @(negedge clk);
        chk("t3_no_same_cycle_credit", trans_valid_o, 0);
        nxt(); resp_valid_i = 1'b0;
        @(negedge clk);
        chk("t3_reissue_valid", trans_valid_o, 1);
        nxt(); idle();
        set_resp(32'h44, 1'b0); exp_resp(1'b1, 32'h44, 1'b0);
        nxt(); set_resp(32'h55, 1'b0); exp_resp(1'b1, 32'h55, 1'b0);
        nxt(); idle();

        // ---- Test 4: D, I, D with responses 1, 2 (err), 3
        set_d(32'h500, 1'b1, 4'hF, 32'hAAAA_0001, 6'h0); exp_data(32'h500, 1'b1, 4'hF, 32'hAAAA_0001, 6'h0);
        nxt(); d_valid_i = 1'b0; i_valid_i = 1'b1; i_addr_i = 32'h600; exp_fetch(32'h600);
        nxt(); i_valid_i = 1'b0;
        set_d(32'h504, 1'b1, 4'h1, 32'hAAAA_0002, 6'h2A); exp_data(32'h504, 1'b1, 4'h1, 32'hAAAA_0002, 6'h2A);
        set_resp(32'h1, 1'b0); exp_resp(1'b0, 32'h1, 1'b0);
        @(negedge clk);
        chk("t4_full_block", trans_valid_o, 0);
        nxt(); resp_valid_i = 1'b0;
        nxt(); d_valid_i = 1'b0; set_resp(32'h2, 1'b1); exp_resp(1'b1, 32'h2, 1'b1);
        @(negedge clk);
        chk("t4_err_not_on_d", d_resp_valid_o, 0);
        chk("t4_err_on_i", {i_resp_valid_o, i_resp_err_o}, 2'b11);
        nxt(); set_resp(32'h3, 1'b0); exp_resp(1'b0, 32'h3, 1'b0);
        nxt(); idle();

        // ---- Reset with two outstanding; late response is dropped
        set_d(32'h600, 1'b0, 4'hF, 32'h0, 6'h0); exp_data(32'h600, 1'b0, 4'hF, 32'h0, 6'h0);
        nxt(); d_valid_i = 1'b0; i_valid_i = 1'b1; i_addr_i = 32'h700; exp_fetch(32'h700);
        nxt(); idle(); rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_trans_valid", trans_valid_o, 0);
        nxt(); rst_n = 1'b1;
        nxt(); set_resp(32'h99, 1'b0);
        @(negedge clk);
        chk("post_rst_resp_dropped", {d_resp_valid_o, i_resp_valid_o}, 0);
        nxt(); idle();

        // ---- Streaming from reset state: both valid, one response per cycle
        set_d(32'h700, 1'b1, 4'h5, 32'hCAFE_0000, 6'h0);
        i_valid_i = 1'b1; i_addr_i = 32'h800;
        for (int k = 0; k < 4; k++) begin
            if (g[k]) exp_fetch(32'h800);
            else      exp_data(32'h700, 1'b1, 4'h5, 32'hCAFE_0000, 6'h0);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                set_resp(32'h70 + k - 1, 1'b0);
                exp_resp(g[k-1], 32'h70 + k - 1, 1'b0);
            end
            @(negedge clk);
            chk("stream_grant", {d_ready_o, i_ready_o}, g[k] ? 2'b01 : 2'b10);
            nxt();
        end
        d_valid_i = 1'b0; i_valid_i = 1'b0;
        set_resp(32'h73, 1'b0); exp_resp(g[3], 32'h73, 1'b0);
        nxt(); idle();
        repeat (3) nxt();

        chk("trans_queue_drained", tq.size(), 0);
        chk("d_resp_queue_drained", dq.size(), 0);
        chk("i_resp_queue_drained", iq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
